// File: rtl/tone_pkg.sv
// Shared types and defaults for the tone measurement blocks.
package tone_pkg;

    localparam int TONE_CNT_W = 20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } tone_state_t;

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer with a history flop and rising-edge strobe.
module sync_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // Synchronizer chain plus one stage of history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= d;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign q    = s2_r;
    assign rise = s2_r & ~s3_r;

endmodule

// File: rtl/tone_period_meter.sv
// Measures period and high time of an asynchronous square wave in clk cycles.
module tone_period_meter
    import tone_pkg::*;
#(
    parameter int CNT_W      = TONE_CNT_W,
    parameter int MAX_PERIOD = 2**CNT_W - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_vld,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    tone_state_t      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] hcnt_r;
    logic             sync_q_s;
    logic             rise_s;

    sync_rise u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sig_in),
        .q     (sync_q_s),
        .rise  (rise_s)
    );

    // Measurement FSM, counters and output registers; en=0 overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            hcnt_r     <= '0;
            period     <= '0;
            high_time  <= '0;
            period_vld <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            period_vld <= 1'b0;
            if (!en) begin
                state_r <= IDLE;
                cnt_r   <= '0;
                hcnt_r  <= '0;
                timeout <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= ARM;
                        cnt_r   <= '0;
                        hcnt_r  <= '0;
                    end
                    ARM: begin
                        if (rise_s) begin
                            state_r <= MEASURE;
                            cnt_r   <= ONE_CNT;
                            hcnt_r  <= ONE_CNT;
                        end else begin
                            state_r <= ARM;
                        end
                    end
                    MEASURE: begin
                        if (rise_s) begin
                            period     <= cnt_r;
                            high_time  <= hcnt_r;
                            period_vld <= 1'b1;
                            timeout    <= 1'b0;
                            cnt_r      <= ONE_CNT;
                            hcnt_r     <= ONE_CNT;
                        end else if (cnt_r == MAX_CNT) begin
                            // Edge never came: flag it and wait for a fresh arming edge.
                            timeout <= 1'b1;
                            state_r <= ARM;
                            cnt_r   <= '0;
                            hcnt_r  <= '0;
                        end else begin
                            cnt_r <= cnt_r + ONE_CNT;
                            if (sync_q_s && (hcnt_r != MAX_CNT)) begin
                                hcnt_r <= hcnt_r + ONE_CNT;
                            end else begin
                                hcnt_r <= hcnt_r;
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                        hcnt_r  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tone_period_meter.sv
// Self-checking bench: two meter instances against an edge-spacing reference model.
module tb_tone_period_meter;
    import tone_pkg::*;

    localparam int HN     = 16384;
    localparam int M_OFF  = 0;
    localparam int M_ARM  = 1;
    localparam int M_MEAS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        sig_in;
    logic [19:0] period_a, high_a;
    logic        vld_a, to_a;
    logic [7:0]  period_b, high_b;
    logic        vld_b, to_b;

    int n_checks = 0;
    int n_err    = 0;

    bit hist [0:HN-1];
    int p;
    int m_max    [2] = '{1048575, 50};
    int m_mode   [2];
    int m_start  [2];
    int m_period [2];
    int m_high   [2];
    int m_vld    [2];
    int m_to     [2];

    tone_period_meter dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
        .period(period_a), .high_time(high_a), .period_vld(vld_a), .timeout(to_a)
    );

    tone_period_meter #(.CNT_W(8), .MAX_PERIOD(50)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
        .period(period_b), .high_time(high_b), .period_vld(vld_b), .timeout(to_b)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < HN; i++) hist[i] = 1'b0;
        p = 3;
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_OFF; m_start[k] = 0; m_period[k] = 0;
            m_high[k] = 0; m_vld[k] = 0; m_to[k] = 0;
        end
    endtask

    // A rise of sig_in is seen by the meter two samples late; spacing between
    // rises is the period and the ones between them are the high time.
    task automatic model_edge();
        bit rise;
        int h;
        p++;
        if (p >= HN) p = HN - 1;
        hist[p] = sig_in;
        rise = hist[p-2] && !hist[p-3];
        for (int k = 0; k < 2; k++) begin
            m_vld[k] = 0;
            if (!en) begin
                m_mode[k] = M_OFF;
                m_to[k]   = 0;
            end else begin
                case (m_mode[k])
                    M_OFF: m_mode[k] = M_ARM;
                    M_ARM: begin
                        if (rise) begin
                            m_mode[k]  = M_MEAS;
                            m_start[k] = p;
                        end
                    end
                    M_MEAS: begin
                        if (rise) begin
                            h = 0;
                            for (int q = m_start[k]; q < p; q++) h += int'(hist[q-2]);
                            m_period[k] = p - m_start[k];
                            m_high[k]   = (h > m_max[k]) ? m_max[k] : h;
                            m_vld[k]    = 1;
                            m_to[k]     = 0;
                            m_start[k]  = p;
                        end else if (p - m_start[k] == m_max[k]) begin
                            m_to[k]   = 1;
                            m_mode[k] = M_ARM;
                        end
                    end
                    default: m_mode[k] = M_OFF;
                endcase
            end
        end
    endtask

    task automatic compare_all();
        check_eq("a_vld",     int'(vld_a),    m_vld[0]);
        check_eq("a_period",  int'(period_a), m_period[0]);
        check_eq("a_high",    int'(high_a),   m_high[0]);
        check_eq("a_timeout", int'(to_a),     m_to[0]);
        check_eq("b_vld",     int'(vld_b),    m_vld[1]);
        check_eq("b_period",  int'(period_b), m_period[1]);
        check_eq("b_high",    int'(high_b),   m_high[1]);
        check_eq("b_timeout", int'(to_b),     m_to[1]);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_a_period"}, int'(period_a), 0);
        check_eq({tag, "_a_high"},   int'(high_a),   0);
        check_eq({tag, "_a_vld"},    int'(vld_a),    0);
        check_eq({tag, "_a_to"},     int'(to_a),     0);
        check_eq({tag, "_b_period"}, int'(period_b), 0);
        check_eq({tag, "_b_high"},   int'(high_b),   0);
        check_eq({tag, "_b_vld"},    int'(vld_b),    0);
        check_eq({tag, "_b_to"},     int'(to_b),     0);
    endtask

    task automatic step(input logic e, input logic s);
        en     = e;
        sig_in = s;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wave(input int per, input int hi, input int n);
        for (int i = 0; i < n; i++) step(1'b1, (i % per) < hi);
    endtask

    initial begin
        int per, hi, len;
        rst_n  = 1'b0;
        en     = 1'b0;
        sig_in = 1'b0;
        model_reset();
        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

        // divide-by-2, then 100/30, then a stuck-low line and a 20-cycle wave
        wave(2, 1, 24);
        wave(100, 30, 450);
        step(1'b1, 1'b1);
        for (int i = 0; i < 70; i++) step(1'b1, 1'b0);
        check_eq("b_timeout_held", int'(to_b), 1);
        wave(20, 10, 100);

        // en dropped exactly when the meter sees a rise
        wave(8, 4, 32);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check_eq("endrop_a_state", int'(dut_a.state_r), int'(IDLE));
        check_eq("endrop_b_state", int'(dut_b.state_r), int'(IDLE));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

        // period change 10 -> 37
        wave(10, 5, 50);
        wave(37, 20, 120);

        // asynchronous reset in the middle of a period
        wave(37, 15, 50);
        #3 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        wave(12, 6, 40);

        // randomized segments with occasional enable drops
        for (int seg = 0; seg < 10; seg++) begin
            per = int'($urandom_range(80, 2));
            hi  = int'($urandom_range(per - 1, 1));
            len = int'($urandom_range(3 * per + 10, 2 * per));
            if ($urandom_range(3, 0) == 0) begin
                for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(1, 0)));
            end
            wave(per, hi, len);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/tone_period_meter.md
TONE_PERIOD_METER -- requirements
Module: tone_period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 20, meaning the width of the period and high-time counters.
REQ-002 SHALL have parameter MAX_PERIOD, default 2**CNT_W-1, meaning the cycle count at which a measurement times out.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state is clocked on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, the reset, which is asynchronous and active-low.
REQ-005 SHALL have port en, input, 1, the measurement enable, synchronous to clk.
REQ-006 SHALL have port sig_in, input, 1, the square wave under test (for example a divided tone clock), asynchronous to clk.
REQ-007 SHALL have port period, output, CNT_W, the last measured rising-edge-to-rising-edge period in clk cycles.
REQ-008 SHALL have port high_time, output, CNT_W, the last measured high-phase length in clk cycles.
REQ-009 SHALL have port period_vld, output, 1, a one-cycle pulse that fires when period and high_time update.
REQ-010 SHALL have port timeout, output, 1, a level flag meaning no rising edge arrived within MAX_PERIOD cycles.

Function
REQ-011 SHALL pass sig_in through a 2-FF synchronizer (s1, s2) and a third history FF (s3); the rise strobe is s2 & ~s3.
REQ-012 SHALL implement the states IDLE, ARM and MEASURE, with state encoding taken from the shared package.
REQ-013 SHALL move IDLE->ARM when en=1; in IDLE, cnt and hcnt are held at 0.
REQ-014 SHALL move ARM->MEASURE on rise, loading cnt=1, and hcnt=1; no period_vld is produced for this first edge.
REQ-015 SHALL, in MEASURE without rise, increment cnt by 1 per cycle, and increment hcnt when s2=1.
REQ-016 SHALL, in MEASURE on rise, register period<=cnt and high_time<=hcnt, assert period_vld on the next cycle only, reload cnt=1 and hcnt=1, and stay in MEASURE.
REQ-017 SHALL produce period equal to the exact spacing of sig_in rising edges (2 for a divide-by-2 wave); synchronizer latency is constant and cancels.
REQ-018 SHALL, in MEASURE when cnt==MAX_PERIOD and rise=0, set timeout=1, leave period and high_time unchanged, and go to ARM; cnt never wraps.
REQ-019 SHALL hold timeout until the next period_vld or until en=0, which clears it.
REQ-020 SHALL, on en=0 in any state, go to IDLE on the next cycle, clear cnt, hcnt and timeout, and suppress any pending period_vld; period and high_time keep their last values.
REQ-021 SHALL give en=0 priority when en=0 coincides with rise; rise has priority over timeout in the same cycle.
REQ-022 SHALL treat hcnt as never exceeding cnt and SHALL saturate it with the same MAX_PERIOD bound.

Reset
REQ-023 SHALL, on rst_n=0, asynchronously set state=IDLE, s1=s2=s3=0, cnt=hcnt=0, period=0, high_time=0, period_vld=0 and timeout=0.
REQ-024 SHALL, on reset asserted mid-measurement, discard the partial count; after release, the first edge only re-arms.

Structure
REQ-025 SHALL place the state enum and the default CNT_W in the shared package tone_pkg.
REQ-026 SHALL implement the synchronizer plus edge detector as the sub-module sync_rise (ports clk, rst_n, d, q, rise), which is reusable by the buzzer blocks.
REQ-027 SHALL keep the FSM, counters and output registers in tone_period_meter itself.

Verification
REQ-028 SHALL cover: en=1, sig_in a divide-by-2 of clk -> after the arming edge, period_vld pulses every 2 cycles with period=2 and high_time=1.
REQ-029 SHALL cover: en=1, sig_in with a 100-cycle period, 30 high -> period=100 and high_time=30 on every pulse, with pulses exactly 100 cycles apart.
REQ-030 SHALL cover: MAX_PERIOD=50, sig_in stuck low after one edge -> timeout=1 exactly 50 cycles after the cnt=1 cycle, period unchanged; a later 20-cycle wave -> after re-arm, period=20 and timeout clears with period_vld.
REQ-031 SHALL cover: en dropped on the same cycle as a rise -> no period_vld, state IDLE next cycle, timeout=0.
REQ-032 SHALL cover: rst_n pulsed low mid-period, asynchronously to clk -> all outputs 0 immediately; the first post-reset edge gives no pulse, and the second gives the correct period.
REQ-033 SHALL cover: period changed from 10 to 37 cycles between edges -> the first affected pulse reports 37 with no stale value.
